// File: rtl/disp_source_sched_if.sv
// disp_source_sched_if: source words and controls in,
// selected display word out.
interface disp_source_sched_if;
   logic [3:0]  src_en;
   logic [3:0]  src_evt;
   logic        hold;
   logic [31:0] src_data0;
   logic [31:0] src_data1;
   logic [31:0] src_data2;
   logic [31:0] src_data3;
   logic [31:0] data_out;
   logic [1:0]  cur_src;
   logic        out_valid;

   modport master (
      output src_en,
      output src_evt,
      output hold,
      output src_data0,
      output src_data1,
      output src_data2,
      output src_data3,
      input  data_out,
      input  cur_src,
      input  out_valid
   );

   modport slave (
      input  src_en,
      input  src_evt,
      input  hold,
      input  src_data0,
      input  src_data1,
      input  src_data2,
      input  src_data3,
      output data_out,
      output cur_src,
      output out_valid
   );
endinterface

// File: rtl/disp_source_sched.sv
// disp_source_sched: round-robin / event-driven picker
// feeding one of four 32-bit words to the 7-seg driver.
module disp_source_sched #(
   parameter int unsigned DWELL = 100_000_000,
   parameter int unsigned CNT_W = 27
) (
   input logic                clk,
   input logic                rst,
   disp_source_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      EVENT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_t           state;
   state_t           state_n;
   logic [1:0]       cur_src;
   logic [1:0]       cur_src_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [3:0]       pend;
   logic [3:0]       pend_n;
   logic [3:0]       evt_ok;
   logic [3:0]       clr;
   logic             enter;
   logic             cur_evt;
   logic [31:0]      sel_data;
   logic [31:0]      data_q;
   logic             valid_q;

   function automatic logic [1:0] lowest(
      input logic [3:0] m
   );
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // first enabled index after x, wrapping back to x
   function automatic logic [1:0] next_src(
      input logic [1:0] x,
      input logic [3:0] en
   );
      logic [1:0] r;
      logic [1:0] idx;
      logic       found;
      r     = x;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = x + 2'(k);
         if (!found && en[idx]) begin
            r     = idx;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // state, selection, dwell counter and pending mask
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cur_src <= 2'd0;
         cnt     <= '0;
         pend    <= 4'd0;
      end else begin
         state   <= state_n;
         cur_src <= cur_src_n;
         cnt     <= cnt_n;
         pend    <= pend_n;
      end
   end

   // next-state decision and pending-mask update
   always_comb begin
      state_n   = state;
      cur_src_n = cur_src;
      cnt_n     = cnt;
      enter     = 1'b0;
      evt_ok    = bus.src_evt & bus.src_en;
      cur_evt   = bus.src_evt[cur_src]
                & bus.src_en[cur_src];
      unique case (state)
         IDLE: begin
            if (|bus.src_en) begin
               state_n   = ROTATE;
               cur_src_n = lowest(bus.src_en);
               cnt_n     = '0;
            end
         end
         ROTATE: begin
            if (bus.src_en == 4'd0) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (!bus.hold) begin
               if (|pend) begin
                  state_n   = EVENT;
                  cur_src_n = lowest(pend);
                  cnt_n     = '0;
                  enter     = 1'b1;
               end else if (!bus.src_en[cur_src]
                            || cnt == LAST) begin
                  cur_src_n = next_src(cur_src,
                                       bus.src_en);
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         EVENT: begin
            if (bus.src_en == 4'd0) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (!bus.hold) begin
               if (cur_evt) begin
                  // re-arm the running event in place
                  cnt_n           = '0;
                  evt_ok[cur_src] = 1'b0;
               end else if (!bus.src_en[cur_src]
                            || cnt == LAST) begin
                  if (|pend) begin
                     cur_src_n = lowest(pend);
                     cnt_n     = '0;
                     enter     = 1'b1;
                  end else begin
                     state_n   = ROTATE;
                     cur_src_n = next_src(cur_src,
                                          bus.src_en);
                     cnt_n     = '0;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_n   = IDLE;
            cur_src_n = 2'd0;
            cnt_n     = '0;
         end
      endcase
      clr    = enter ? (4'b0001 << cur_src_n)
                     : 4'b0000;
      pend_n = ((pend & ~clr) | evt_ok)
             & bus.src_en;
   end

   // mux the live word of the selected source
   always_comb begin
      sel_data = bus.src_data0;
      unique case (cur_src)
         2'd0: sel_data = bus.src_data0;
         2'd1: sel_data = bus.src_data1;
         2'd2: sel_data = bus.src_data2;
         2'd3: sel_data = bus.src_data3;
         default: sel_data = bus.src_data0;
      endcase
   end

   // output register, one cycle behind cur_src
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state != IDLE);
         data_q  <= (state != IDLE) ? sel_data
                                    : 32'd0;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.cur_src   = cur_src;

endmodule
